// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants and total-length helpers
package vga_timing_pkg;

    localparam int COORD_W     = 10;
    localparam int COORD_LIMIT = 1 << COORD_W;

    localparam int VGA_CLK_DIV  = 4;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from the timing generator to the display pipeline
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic               p_tick;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               video_on;
    logic               hsync;
    logic               vsync;
    logic               frame_start;

    modport master (output p_tick, x, y, video_on, hsync, vsync, frame_start);
    modport slave  (input  p_tick, x, y, video_on, hsync, vsync, frame_start);

endinterface

// File: rtl/sig_delay_line.sv
// rtl/sig_delay_line.sv - generic shift register with async reset to a supplied reset value
module sig_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = ^{clk, rst, rst_val_i};
        assign dout_o    = din_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= rst_val_i;
            end else begin
                stage_q[0] <= din_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign dout_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running raster timing: pixel divider, h/v counters, sync decode
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV    = VGA_CLK_DIV,
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int PIPE_DELAY = 1
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_total
        $error("vga_timing_gen: line or frame total exceeds the 10-bit coordinate range");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 2");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY must be within 0..7");
    end

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    // Delay-line order is {video_on, hsync, vsync}; idle means blanked with syncs inactive.
    localparam logic [2:0]         RAW_IDLE = {1'b0, ~SYNC_POL, ~SYNC_POL};

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               frame_start_q, frame_start_d;
    logic               tick;
    logic               x_wrap;
    logic               y_wrap;
    logic               hs_raw, vs_raw, vo_raw;
    logic [2:0]         raw;
    logic [2:0]         delayed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        tick          = (div_q == DIV_LAST);
        x_wrap        = (x_q == H_LAST);
        y_wrap        = (y_q == V_LAST);
        div_d         = tick ? '0 : div_q + DIV_W'(1);
        x_d           = x_q;
        y_d           = y_q;
        frame_start_d = tick && x_wrap && y_wrap;
        if (tick) begin
            x_d = x_wrap ? '0 : x_q + COORD_W'(1);
            if (x_wrap) begin
                y_d = y_wrap ? '0 : y_q + COORD_W'(1);
            end
        end
    end

    assign hs_raw = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
    assign vs_raw = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
    assign vo_raw = (x_q < H_VIS) && (y_q < V_VIS);
    assign raw    = {vo_raw, hs_raw ? SYNC_POL : ~SYNC_POL, vs_raw ? SYNC_POL : ~SYNC_POL};

    // Keeps syncs and blanking aligned with the one-clock-late image ROM data.
    sig_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_DELAY)
    ) u_delay (
        .clk       (clk),
        .rst       (reset),
        .rst_val_i (RAW_IDLE),
        .din_i     (raw),
        .dout_o    (delayed)
    );

    assign vga.p_tick      = tick;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.video_on    = delayed[2];
    assign vga.hsync       = delayed[1];
    assign vga.vsync       = delayed[0];
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of raster timing, sync alignment and reset behaviour
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [1:0] sel = 2'd0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if if0 ();
    vga_timing_gen_if if1 ();
    vga_timing_gen_if if3 ();

    vga_timing_gen dut_a (.clk(clk), .reset(rst_a), .vga(ifa));

    // Small raster: line 15 px (hs 10..12), frame 10 lines (vs 7..8), 2 clk per pixel.
    vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .PIPE_DELAY(0))
        dut_s0 (.clk(clk), .reset(rst_b), .vga(if0));
    vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .PIPE_DELAY(1))
        dut_s1 (.clk(clk), .reset(rst_b), .vga(if1));
    vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .PIPE_DELAY(3))
        dut_s3 (.clk(clk), .reset(rst_b), .vga(if3));

    logic [24:0] bus [4];
    assign bus[0] = {ifa.p_tick, ifa.x, ifa.y, ifa.video_on, ifa.hsync, ifa.vsync, ifa.frame_start};
    assign bus[1] = {if0.p_tick, if0.x, if0.y, if0.video_on, if0.hsync, if0.vsync, if0.frame_start};
    assign bus[2] = {if1.p_tick, if1.x, if1.y, if1.video_on, if1.hsync, if1.vsync, if1.frame_start};
    assign bus[3] = {if3.p_tick, if3.x, if3.y, if3.video_on, if3.hsync, if3.vsync, if3.frame_start};

    logic       m_pt, m_vo, m_hs, m_vs, m_fs;
    logic [9:0] m_x, m_y;
    assign {m_pt, m_x, m_y, m_vo, m_hs, m_vs, m_fs} = bus[sel];

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int key_of(input int kind);
        return (kind == 2) ? int'(m_y) : int'(m_x);
    endfunction

    function automatic logic flag_of(input int kind);
        case (kind)
            0:       return m_hs;
            1:       return m_vo;
            default: return m_vs;
        endcase
    endfunction

    // kind 0: hsync vs x, 1: video_on vs x (only on lines y<ymax), 2: vsync vs y.
    task automatic lag_meas(input int kind, input int val, input int ymax, output int lag);
        int n;
        n = 0;
        while (key_of(kind) == val && n < 8000) begin @(negedge clk); n++; end
        while (!(key_of(kind) == val && int'(m_y) < ymax) && n < 8000) begin @(negedge clk); n++; end
        lag = 0;
        while (flag_of(kind) != 1'b0 && lag < 16) begin @(negedge clk); lag++; end
        if (n >= 8000) lag = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bad, n, lag, px, pts, hs_lo, vs_lo, vo_hi, fs_cnt, xmax, ymax;
        int         want_lag [3];
        logic [7:0] pt_hist;

        want_lag = '{0, 1, 3};
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (ifa.hsync !== 1'b1 || ifa.vsync !== 1'b1 || ifa.video_on !== 1'b0 ||
                ifa.p_tick !== 1'b0 || ifa.frame_start !== 1'b0) bad++;
        end
        chk("a_reset_hold_bad_samples", bad, 0);
        chk("a_reset_x", int'(ifa.x), 0);
        chk("a_reset_y", int'(ifa.y), 0);

        rst_a = 1'b0;
        pt_hist = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pt_hist[i] = ifa.p_tick;
            if (i == 6) chk("a_x_on_second_tick", int'(ifa.x), 1);
        end
        chk("a_ptick_pattern", int'(pt_hist), 68);
        chk("a_x_after_8_clk", int'(ifa.x), 2);

        lag_meas(1, 640, 480, lag);
        chk("a_video_on_fall_lag", lag, 1);
        lag_meas(0, 656, 1024, lag);
        chk("a_hsync_fall_lag", lag, 1);

        n = 0;
        while (m_x != 10'd799 && n < 4000) begin @(negedge clk); n++; end
        while (m_x != 10'd0 && n < 4000) begin @(negedge clk); n++; end
        chk("a_line_wrap_seen", int'(n < 4000), 1);
        n = 0; pts = 0; hs_lo = 0; xmax = 0;
        do begin
            px = int'(m_x);
            @(negedge clk);
            n++;
            pts   += int'(m_pt);
            hs_lo += int'(!m_hs);
            if (int'(m_x) > xmax) xmax = int'(m_x);
        end while (!(px == 799 && m_x == 10'd0) && n < 4000);
        chk("a_line_clk", n, 3200);
        chk("a_line_pticks", pts, 800);
        chk("a_hsync_low_clk", hs_lo, 384);
        chk("a_x_max", xmax, 799);

        sel = 2'd2;
        #1;
        chk("s1_reset_x", int'(m_x), 0);
        chk("s1_reset_video_on", int'(m_vo), 0);
        chk("s1_reset_hsync", int'(m_hs), 1);
        chk("s1_reset_vsync", int'(m_vs), 1);
        rst_b = 1'b0;

        for (int k = 0; k < 3; k++) begin
            sel = 2'(k + 1);
            #1;
            lag_meas(1, 8, 6, lag);
            chk($sformatf("s%0d_video_on_lag", want_lag[k]), lag, want_lag[k]);
            lag_meas(0, 10, 1024, lag);
            chk($sformatf("s%0d_hsync_lag", want_lag[k]), lag, want_lag[k]);
            lag_meas(2, 7, 1024, lag);
            chk($sformatf("s%0d_vsync_lag", want_lag[k]), lag, want_lag[k]);
        end

        sel = 2'd2;
        #1;
        n = 0;
        while (!(m_pt && m_x == 10'd14 && m_y == 10'd9) && n < 1000) begin @(negedge clk); n++; end
        chk("s1_corner_reached", int'(n < 1000), 1);
        @(negedge clk);
        chk("s1_wrap_x", int'(m_x), 0);
        chk("s1_wrap_y", int'(m_y), 0);
        chk("s1_wrap_frame_start", int'(m_fs), 1);
        n = 0; pts = 0; vs_lo = 0; vo_hi = 0; xmax = 0; ymax = 0;
        do begin
            @(negedge clk);
            n++;
            pts   += int'(m_pt);
            vs_lo += int'(!m_vs);
            vo_hi += int'(m_vo);
            if (int'(m_x) > xmax) xmax = int'(m_x);
            if (int'(m_y) > ymax) ymax = int'(m_y);
        end while (!m_fs && n < 1000);
        chk("s1_frame_clk", n, 300);
        chk("s1_frame_pticks", pts, 150);
        chk("s1_vsync_low_clk", vs_lo, 60);
        chk("s1_video_on_clk", vo_hi, 96);
        chk("s1_x_max", xmax, 14);
        chk("s1_y_max", ymax, 9);
        @(negedge clk);
        chk("s1_frame_start_width", int'(m_fs), 0);

        n = 0;
        while (!(m_x == 10'd5 && m_y == 10'd4) && n < 1000) begin @(negedge clk); n++; end
        chk("s1_mid_point_reached", int'(n < 1000), 1);
        #2 rst_b = 1'b1;
        #1;
        chk("s1_async_reset_x", int'(m_x), 0);
        chk("s1_async_reset_y", int'(m_y), 0);
        chk("s1_async_reset_video_on", int'(m_vo), 0);
        chk("s1_async_reset_ptick", int'(m_pt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        fs_cnt = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            fs_cnt += int'(m_fs);
            if (i == 1) chk("s1_restart_x0", int'(m_x), 0);
            if (i == 2) chk("s1_restart_x1", int'(m_x), 1);
        end
        chk("s1_no_spurious_frame_start", fs_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
